// File: rtl/cv32e40px_x_wb_seq.sv
// Coprocessor result write-back sequencer.
// Buffers coprocessor result beats in a small FIFO and serialises them onto a
// single register file write port. Dual results are written as two phases
// (even register, then odd register). A per-register pending scoreboard is
// derived from the buffered entries so decode can stall on RAW hazards.
module cv32e40px_x_wb_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      kill_i,
  input  logic                      result_valid_i,
  output logic                      result_ready_o,
  input  logic [ADDR_WIDTH-1:0]     result_rd_i,
  input  logic [2*DATA_WIDTH-1:0]   result_data_i,
  input  logic                      result_we_i,
  input  logic                      result_dual_i,
  input  logic                      rf_gnt_i,
  output logic                      rf_we_o,
  output logic [ADDR_WIDTH-1:0]     rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic [2**ADDR_WIDTH-1:0]  pending_o,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;   // base address (bit 0 cleared for dual)
    logic [2*DATA_WIDTH-1:0] data;
    logic                    dual;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } state_e;

  entry_t                mem [DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr, count;
  state_e                state_q, state_d;
  entry_t                head;
  entry_t                scan_e;
  logic                  full, push, pop, active, phase_done, more;
  logic [2**ADDR_WIDTH-1:0] pend_vec;

  // Occupancy uses one extra pointer bit so full and empty are distinguishable.
  assign count          = wr_ptr - rd_ptr;
  assign full           = (count == (PTR_W+1)'(DEPTH));
  assign result_ready_o = !full && !kill_i;
  // Beats that do not write the register file are accepted and discarded.
  assign push           = result_valid_i && result_ready_o && result_we_i;
  assign head           = mem[rd_ptr[PTR_W-1:0]];
  assign active         = (state_q != IDLE);
  assign busy_o         = active;

  // Present the current head phase on the register file write port.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    unique case (state_q)
      WR_LO: begin
        rf_waddr_o = head.addr;
        rf_wdata_o = head.data[DATA_WIDTH-1:0];
      end
      WR_HI: begin
        rf_waddr_o = {head.addr[ADDR_WIDTH-1:1], 1'b1};
        rf_wdata_o = head.data[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
    // x0 writes are suppressed but still retire in one cycle.
    rf_we_o = active && (rf_waddr_o != '0);
  end

  assign phase_done = active && (!rf_we_o || rf_gnt_i);
  assign pop        = phase_done && (state_q == WR_HI || !head.dual);
  // Another entry remains after the pop, either already buffered or arriving now.
  assign more       = (count > (PTR_W+1)'(1)) || push;

  // Head sequencing: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (push) state_d = WR_LO;
      WR_LO: if (phase_done) state_d = head.dual ? WR_HI : (more ? WR_LO : IDLE);
      WR_HI: if (phase_done) state_d = more ? WR_LO : IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // State register and FIFO pointers; kill flushes everything next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments throughout.
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (kill_i) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Result storage; dual entries keep the even base address.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; validity is defined solely by the pointers.
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{
        addr: result_dual_i ? {result_rd_i[ADDR_WIDTH-1:1], 1'b0} : result_rd_i,
        data: result_data_i,
        dual: result_dual_i
      };
    end
  end

  // Scoreboard: a register is pending while any buffered phase still targets it.
  always_comb begin
    pend_vec = '0;
    scan_e   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count) begin
        scan_e = mem[rd_ptr[PTR_W-1:0] + PTR_W'(i)];
        // The lower half of a dual head has already retired once in WR_HI.
        if (!(i == 0 && state_q == WR_HI)) pend_vec[scan_e.addr] = 1'b1;
        if (scan_e.dual) pend_vec[{scan_e.addr[ADDR_WIDTH-1:1], 1'b1}] = 1'b1;
      end
    end
    pend_vec[0] = 1'b0;
    pending_o   = pend_vec;
  end

endmodule

// File: tb/tb_cv32e40px_x_wb_seq.sv
// Self-checking bench for cv32e40px_x_wb_seq: directed scenarios followed by
// random traffic, all compared against a queue-of-write-operations model.
module tb_cv32e40px_x_wb_seq;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              kill_i = 1'b0;
  logic              result_valid_i = 1'b0;
  logic              result_ready_o;
  logic [AW-1:0]     result_rd_i = '0;
  logic [2*DW-1:0]   result_data_i = '0;
  logic              result_we_i = 1'b0;
  logic              result_dual_i = 1'b0;
  logic              rf_gnt_i = 1'b0;
  logic              rf_we_o;
  logic [AW-1:0]     rf_waddr_o;
  logic [DW-1:0]     rf_wdata_o;
  logic [2**AW-1:0]  pending_o;
  logic              busy_o;

  cv32e40px_x_wb_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kill_i         (kill_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .result_rd_i    (result_rd_i),
    .result_data_i  (result_data_i),
    .result_we_i    (result_we_i),
    .result_dual_i  (result_dual_i),
    .rf_gnt_i       (rf_gnt_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .pending_o      (pending_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted write beat expands into one or two
  // register writes, retired in order; 'last' marks the end of a beat.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } op_t;

  op_t ops[$];
  int  beats = 0;

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input bit v, input logic [AW-1:0] rd, input logic [63:0] d,
                      input bit we, input bit dual, input bit gnt, input bit kill);
    bit               exp_ready;
    logic [2**AW-1:0] exp_pend;
    result_valid_i = v;
    result_rd_i    = rd;
    result_data_i  = d;
    result_we_i    = we;
    result_dual_i  = dual;
    rf_gnt_i       = gnt;
    kill_i         = kill;
    #1;
    exp_ready = (beats < DEPTH) && !kill;
    exp_pend  = '0;
    foreach (ops[k]) if (ops[k].addr != 0) exp_pend[ops[k].addr] = 1'b1;
    check("ready", 64'(result_ready_o), 64'(exp_ready));
    check("busy", 64'(busy_o), 64'(ops.size() > 0));
    check("pending", 64'(pending_o), 64'(exp_pend));
    if (ops.size() > 0) begin
      check("rf_we", 64'(rf_we_o), 64'(ops[0].addr != 0));
      check("rf_waddr", 64'(rf_waddr_o), 64'(ops[0].addr));
      check("rf_wdata", 64'(rf_wdata_o), 64'(ops[0].data));
    end else begin
      check("rf_we_idle", 64'(rf_we_o), 64'd0);
      check("rf_waddr_idle", 64'(rf_waddr_o), 64'd0);
      check("rf_wdata_idle", 64'(rf_wdata_o), 64'd0);
    end
    if (kill) begin
      ops.delete();
      beats = 0;
    end else begin
      if (ops.size() > 0 && (ops[0].addr == 0 || gnt)) begin
        if (ops[0].last) beats--;
        void'(ops.pop_front());
      end
      if (v && exp_ready && we) begin
        if (dual) begin
          ops.push_back('{addr: {rd[AW-1:1], 1'b0}, data: d[31:0], last: 1'b0});
          ops.push_back('{addr: {rd[AW-1:1], 1'b1}, data: d[63:32], last: 1'b1});
        end else begin
          ops.push_back('{addr: rd, data: d[31:0], last: 1'b1});
        end
        beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit gnt);
    step(1'b0, '0, '0, 1'b0, 1'b0, gnt, 1'b0);
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_we", 64'(rf_we_o), 64'd0);
    check("rst_waddr", 64'(rf_waddr_o), 64'd0);
    check("rst_wdata", 64'(rf_wdata_o), 64'd0);
    check("rst_pending", 64'(pending_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 64'(result_ready_o), 64'd1);

    // Single write to x5.
    step(1'b1, 5'd5, 64'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    check("single_we", 64'(rf_we_o), 64'd1);
    check("single_waddr", 64'(rf_waddr_o), 64'd5);
    check("single_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);
    check("single_pend_set", 64'(pending_o[5]), 64'd1);
    idle(1'b1);
    check("single_pend_clr", 64'(pending_o[5]), 64'd0);
    check("single_done_we", 64'(rf_we_o), 64'd0);

    // Dual write to pair x6/x7.
    step(1'b1, 5'd7, 64'h11112222_33334444, 1'b1, 1'b1, 1'b1, 1'b0);
    check("dual_lo_waddr", 64'(rf_waddr_o), 64'd6);
    check("dual_lo_wdata", 64'(rf_wdata_o), 64'h33334444);
    check("dual_lo_pend", 64'(pending_o[7:6]), 64'b11);
    idle(1'b1);
    check("dual_hi_waddr", 64'(rf_waddr_o), 64'd7);
    check("dual_hi_wdata", 64'(rf_wdata_o), 64'h11112222);
    check("dual_hi_pend", 64'(pending_o[7:6]), 64'b10);
    idle(1'b1);
    check("dual_done_pend", 64'(pending_o[7:6]), 64'b00);

    // Backpressure: grant withheld, three beats offered to a two-entry buffer.
    step(1'b1, 5'd3, 64'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd4, 64'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd8, 64'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_hold_waddr", 64'(rf_waddr_o), 64'd3);
    check("bp_hold_wdata", 64'(rf_wdata_o), 64'hA1);
    step(1'b1, 5'd8, 64'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd8, 64'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) idle(1'b1);

    // x0 targets: dual pair x0/x1, then a single x0 write.
    step(1'b1, 5'd0, 64'hAAAA0000_BBBB0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("x0_lo_we", 64'(rf_we_o), 64'd0);
    idle(1'b0);
    check("x0_hi_we", 64'(rf_we_o), 64'd1);
    check("x0_hi_waddr", 64'(rf_waddr_o), 64'd1);
    idle(1'b1);
    step(1'b1, 5'd0, 64'hCAFE, 1'b1, 1'b0, 1'b1, 1'b0);
    check("x0_single_pend", 64'(pending_o), 64'd0);
    idle(1'b1);
    check("x0_single_we", 64'(rf_we_o), 64'd0);

    // Kill while a dual result is in its upper phase with another entry queued.
    step(1'b1, 5'd10, 64'h5555_6666, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd12, 64'h7777, 1'b1, 1'b0, 1'b1, 1'b0);
    check("kill_pre_waddr", 64'(rf_waddr_o), 64'd11);
    step(1'b1, 5'd14, 64'h8888, 1'b1, 1'b0, 1'b0, 1'b1);
    check("kill_busy", 64'(busy_o), 64'd0);
    check("kill_pending", 64'(pending_o), 64'd0);
    check("kill_we", 64'(rf_we_o), 64'd0);
    idle(1'b1);

    // Asynchronous reset in the middle of a dual result.
    step(1'b1, 5'd20, 64'h9999_AAAA, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(rf_we_o), 64'd0);
    check("mid_rst_pending", 64'(pending_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    ops.delete();
    beats = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1);

    // Random traffic on a small register range to provoke overlapping targets.
    repeat (3000) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), {$urandom, $urandom},
           $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    repeat (4) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40px_x_wb_seq.md
CV32E40PX_X_WB_SEQ -- requirements
Module: cv32e40px_x_wb_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, integer register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one register word.
REQ-003 SHALL have parameter DEPTH, default 2, result buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port kill_i  input  1  synchronous flush of all buffered results.
REQ-007 SHALL have port result_valid_i  input  1  coprocessor result beat valid.
REQ-008 SHALL have port result_ready_o  output  1  sequencer can accept a beat.
REQ-009 SHALL have port result_rd_i  input  ADDR_WIDTH  destination register.
REQ-010 SHALL have port result_data_i  input  2*DATA_WIDTH  result data; upper half used only for dual writes.
REQ-011 SHALL have port result_we_i  input  1  result writes the register file.
REQ-012 SHALL have port result_dual_i  input  1  result writes the even/odd register pair.
REQ-013 SHALL have port rf_gnt_i  input  1  register file write port available this cycle.
REQ-014 SHALL have port rf_we_o  output  1  register file write enable.
REQ-015 SHALL have port rf_waddr_o  output  ADDR_WIDTH  register file write address.
REQ-016 SHALL have port rf_wdata_o  output  DATA_WIDTH  register file write data.
REQ-017 SHALL have port pending_o  output  2**ADDR_WIDTH  per-register write-pending scoreboard for decode RAW stalls.
REQ-018 SHALL have port busy_o  output  1  buffer non-empty or write in progress.

Function
REQ-019 SHALL accept a beat on result_valid_i && result_ready_o; result_ready_o = buffer not full && !kill_i (no path from rf_gnt_i).
REQ-020 SHALL drop accepted beats with result_we_i=0 without buffering; no write, no pending bit.
REQ-021 SHALL buffer accepted write beats in FIFO order; dual beats store base address result_rd_i with bit 0 cleared.
REQ-022 SHALL use head FSM states IDLE (empty), WR_LO (single write or lower half of dual), WR_HI (upper half of dual).
REQ-023 SHALL in WR_LO drive rf_waddr_o = head address, rf_wdata_o = data[DATA_WIDTH-1:0]; in WR_HI drive address|1, data[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-024 SHALL assert rf_we_o in WR_LO/WR_HI unless target address is 0; an x0 target completes in one cycle regardless of rf_gnt_i, with rf_we_o=0.
REQ-025 SHALL complete a phase when rf_we_o && rf_gnt_i; otherwise hold all rf_* outputs stable.
REQ-026 SHALL transition WR_LO->WR_HI on completion of a dual head; WR_LO (single) or WR_HI completion pops the head and goes to WR_LO if more entries, else IDLE.
REQ-027 SHALL allow push and pop in the same cycle; a beat accepted into an empty buffer is presented no earlier than the next cycle (one-cycle latency to rf_we_o).
REQ-028 SHALL set pending_o bit(s) for the target register (both of the pair for dual) in the cycle after acceptance; bit 0 always 0.
REQ-029 SHALL clear a pending bit in the cycle after its write phase completes, unless another buffered entry targets the same register.
REQ-030 SHALL on kill_i empty the buffer, return FSM to IDLE, clear pending_o and drop any same-cycle incoming beat, effective next cycle; rf_we_o remains visible during the kill cycle.
REQ-031 SHALL assert busy_o whenever FSM is not IDLE.

Reset
REQ-032 SHALL on rst_n=0 asynchronously clear buffer, FSM=IDLE, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pending_o=0, busy_o=0; result_ready_o=1 after release.
REQ-033 SHALL discard any partially written dual result on reset mid-operation.

Verification
REQ-034 Single: rd=5, data lo=0xDEADBEEF, we=1, gnt=1 -> next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF; pending_o[5] 1 for one cycle then 0.
REQ-035 Dual: rd=7, data=0x11112222_33334444, gnt=1 -> cycle1 waddr=6 wdata=0x33334444, cycle2 waddr=7 wdata=0x11112222; pending_o[6],[7] clear in order.
REQ-036 Backpressure: gnt=0 for 3 cycles with DEPTH=2 and 3 beats offered -> rf_* stable, result_ready_o=0 after 2 accepts, third accepted after first pop.
REQ-037 x0: dual rd=0 -> cycle1 rf_we_o=0 (x0 suppressed, ignores gnt), cycle2 waddr=1 we=1; single rd=0 -> no write, no pending bit.
REQ-038 Kill mid-dual: kill_i during WR_HI with one more entry queued -> next cycle IDLE, pending_o=0, busy_o=0, result_ready_o=1, no further rf_we_o.
